// File: rtl/tpf_fir_prog_if.sv
// Sample, coefficient and result signals of the programmable FIR filter.
// The master side is the sample/coefficient source, which also observes results.
// The slave side is the filter itself.
interface tpf_fir_prog_if #(
    parameter int DW = 16,
    parameter int CW = 3,
    parameter int OW = 19
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          coef_valid;
    logic [CW-1:0] coef_data;
    logic          out_valid;
    logic [OW-1:0] out_data;
    logic          ovf;
    logic          busy;

    modport master (
        output in_valid, in_data, coef_valid, coef_data,
        input  in_ready, out_valid, out_data, ovf, busy
    );

    modport slave (
        input  in_valid, in_data, coef_valid, coef_data,
        output in_ready, out_valid, out_data, ovf, busy
    );
endinterface

// File: rtl/tpf_fir_prog.sv
// Transposed-form FIR filter with run-time loadable coefficients.
// Samples use a valid/ready handshake, and each accepted sample yields one
// registered result on the following cycle. Coefficients are written
// c[0] first. The first word arrives in RUN and the rest arrive in LOAD.
// A single FLUSH cycle then clears the partial sums and the sticky ovf flag.
// Optional feature macro FIR_SAT_EN: when defined, results above 2^OW-1 saturate.
// When it is undefined, those results wrap to their low OW bits.
module tpf_fir_prog #(
    parameter int DW   = 16,
    parameter int CW   = 3,
    parameter int TAPS = 4,
    parameter int OW   = 19
) (
    input  logic            clk,
    input  logic            rst,
    tpf_fir_prog_if.slave   bus
);
    localparam int AW = DW + CW + $clog2(TAPS);
    // Extended width, so the overflow test always has at least one bit above OW.
    localparam int EW = (AW > OW) ? AW : OW + 1;
    localparam int IW = $clog2(TAPS);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [IW-1:0]   idx_r;
    logic [IW-1:0]   idx_nxt_s;
    logic            c_we_s;
    logic [IW-1:0]   c_widx_s;
    logic [CW-1:0]   c_r [TAPS];
    logic [AW-1:0]   s_r [TAPS-1];
    logic [AW-1:0]   prod_s [TAPS];
    logic [AW-1:0]   y_s;
    logic [EW-1:0]   y_ext_s;
    logic            y_ovf_s;
    logic [OW-1:0]   y_conv_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            out_valid_r;
    logic [OW-1:0]   out_data_r;
    logic            ovf_r;

    // A sample is refused in RUN whenever a coefficient word is offered.
    assign in_ready_s = (state_r == ST_RUN) && !bus.coef_valid;
    assign accept_s   = bus.in_valid && in_ready_s;

    // Products of the current sample with every coefficient, plus the finished sum.
    always_comb begin
        for (int k = 0; k < TAPS; k++) begin
            prod_s[k] = AW'(c_r[k]) * AW'(bus.in_data);
        end
        y_s      = s_r[0] + prod_s[0];
        y_ext_s  = EW'(y_s);
        y_ovf_s  = |y_ext_s[EW-1:OW];
`ifdef FIR_SAT_EN
        if (y_ovf_s) begin
            y_conv_s = {OW{1'b1}};
        end else begin
            y_conv_s = y_ext_s[OW-1:0];
        end
`else
        y_conv_s = y_ext_s[OW-1:0];
`endif
    end

    // Control state register and coefficient write index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            idx_r   <= {IW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
        end
    end

    // Next-state logic and coefficient write strobes.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        c_we_s      = 1'b0;
        c_widx_s    = {IW{1'b0}};
        case (state_r)
            ST_RUN: begin
                if (bus.coef_valid) begin
                    c_we_s      = 1'b1;
                    c_widx_s    = {IW{1'b0}};
                    idx_nxt_s   = IW'(1);
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (bus.coef_valid) begin
                    c_we_s   = 1'b1;
                    c_widx_s = idx_r;
                    if (idx_r == IW'(TAPS - 1)) begin
                        idx_nxt_s   = {IW{1'b0}};
                        state_nxt_s = ST_FLUSH;
                    end else begin
                        idx_nxt_s   = idx_r + IW'(1);
                    end
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                state_nxt_s = ST_RUN;
            end
            default: begin
                state_nxt_s = ST_RUN;
                idx_nxt_s   = {IW{1'b0}};
            end
        endcase
    end

    // Coefficient bank. Reset restores the default ramp 1, 2, 3, ...
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                c_r[k] <= CW'(k + 1);
            end
        end else if (c_we_s) begin
            c_r[c_widx_s] <= bus.coef_data;
        end
    end

    // Transposed partial-sum chain. It advances only on accept and is cleared by FLUSH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < TAPS - 1; k++) begin
                s_r[k] <= {AW{1'b0}};
            end
        end else if (state_r == ST_FLUSH) begin
            for (int k = 0; k < TAPS - 1; k++) begin
                s_r[k] <= {AW{1'b0}};
            end
        end else if (accept_s) begin
            for (int k = 0; k < TAPS - 2; k++) begin
                s_r[k] <= s_r[k+1] + prod_s[k+1];
            end
            s_r[TAPS-2] <= prod_s[TAPS-1];
        end
    end

    // Registered result, one-cycle valid pulse and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OW{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            out_valid_r <= accept_s;
            if (accept_s) begin
                out_data_r <= y_conv_s;
            end
            if (state_r == ST_FLUSH) begin
                ovf_r <= 1'b0;
            end else if (accept_s && y_ovf_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.busy      = (state_r != ST_RUN);
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.ovf       = ovf_r;

endmodule
